// File: rtl/instruction_fetch.sv
// Fetch-side initiator for a synchronous instruction memory: owns the PC,
// tracks one in-flight read and buffers returned words for decode.
module instruction_fetch #(
    parameter int unsigned       ADDR_W     = 6,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic              inflight;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] buf_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] buf_pc   [FIFO_DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [SUM_W-1:0]  used;
    logic [SUM_W-1:0]  limit;

    // Issue only when the buffer can absorb everything already requested.
    always_comb begin
        pop   = 1'b0;
        push  = 1'b0;
        issue = 1'b0;
        used  = SUM_W'(count) + SUM_W'(inflight);
        limit = SUM_W'(FIFO_DEPTH);
        pop   = inst_valid & inst_ready;
        push  = inflight & ~redirect_valid;
        limit = SUM_W'(FIFO_DEPTH) + SUM_W'(pop);
        issue = fetch_en & ~redirect_valid & (used < limit);
    end

    // PC, in-flight tracking and return buffer; redirect flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                inflight <= 1'b1;
                tag      <= pc;
                pc       <= pc + ADDR_W'(1);
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                buf_data[wr_ptr] <= im_rdata;
                buf_pc[wr_ptr]   <= tag;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign im_addr    = pc;
    assign inst_valid = (count != '0);
    assign inst       = buf_data[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];

endmodule
